// File: rtl/shift_r_int16_pipe_pkg.sv
// Shared widths and the sign-filling shift helper for the shift_r_int16_pipe datapath.
// Both pipeline stages call asr_fill so they shift the same way.
package shift_r_pkg;

  localparam int SHIFT_R_WIDTH       = 16;
  localparam int SHIFT_R_SHIFT_WIDTH = 4;

  function automatic logic [SHIFT_R_WIDTH-1:0] asr_fill(
    input logic [SHIFT_R_WIDTH-1:0]       data,
    input logic [SHIFT_R_SHIFT_WIDTH-1:0] amt
  );
    return $signed(data) >>> amt;
  endfunction

endpackage

// File: rtl/shift_r_int16_pipe_if.sv
// Operand/result handshake bundle for shift_r_int16_pipe.
// The slave modport is the shifter's view; the master modport is the producer/consumer view.
interface shift_r_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Y
  );

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Y
  );
endinterface

// File: rtl/shift_r_int16_pipe_stage.sv
// One valid/ready register slice. It loads whenever it is empty or its consumer takes the
// current item, so a full pipeline still moves every cycle while the downstream end is ready.
module shift_r_pipe_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  assign ready = !out_valid || out_ready;

  // Data only loads with a valid item, so the output holds its last value during bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/shift_r_int16_pipe.sv
// Two-stage handshaked arithmetic right shifter: stage 1 shifts by B[1:0], stage 2 by 4*B[3:2].
// Build option SHIFT_R_OVERSHIFT_EN: a nonzero B[15:4] forces the result to full sign fill.
module shift_r_int16_pipe
  import shift_r_pkg::*;
#(
  parameter int WIDTH       = SHIFT_R_WIDTH,
  parameter int SHIFT_WIDTH = SHIFT_R_SHIFT_WIDTH
) (
  input logic     clk,
  input logic     rst,
  shift_r_if.slave bus
);

`ifdef SHIFT_R_OVERSHIFT_EN
  localparam int S1_W = WIDTH + 3;
`else
  localparam int S1_W = WIDTH + 2;
`endif

  logic [S1_W-1:0]  s1_in;
  logic [S1_W-1:0]  s1_q;
  logic             s1_valid;
  logic             s1_ready;
  logic             s2_ready;
  logic [WIDTH-1:0] d1_in;
  logic [WIDTH-1:0] d1;
  logic [1:0]       sh2;
  logic [WIDTH-1:0] d2;

  assign d1_in = asr_fill(bus.A, {2'b00, bus.B[1:0]});

`ifdef SHIFT_R_OVERSHIFT_EN
  assign s1_in = {(|bus.B[WIDTH-1:SHIFT_WIDTH]), bus.B[SHIFT_WIDTH-1:SHIFT_WIDTH-2], d1_in};
`else
  assign s1_in = {bus.B[SHIFT_WIDTH-1:SHIFT_WIDTH-2], d1_in};
  logic unused_b_hi;
  assign unused_b_hi = ^bus.B[WIDTH-1:SHIFT_WIDTH];
`endif

  shift_r_pipe_stage #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_data   (s1_in),
    .ready     (s1_ready),
    .out_valid (s1_valid),
    .out_data  (s1_q),
    .out_ready (s2_ready)
  );

  assign d1  = s1_q[WIDTH-1:0];
  assign sh2 = s1_q[WIDTH+1:WIDTH];

  // d1 already carries A's sign bit in its MSB, so it is the fill source for overshift.
`ifdef SHIFT_R_OVERSHIFT_EN
  assign d2 = s1_q[WIDTH+2] ? {WIDTH{d1[WIDTH-1]}} : asr_fill(d1, {sh2, 2'b00});
`else
  assign d2 = asr_fill(d1, {sh2, 2'b00});
`endif

  shift_r_pipe_stage #(.DW(WIDTH)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_data   (d2),
    .ready     (s2_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.Y),
    .out_ready (bus.out_ready)
  );

  assign bus.in_ready = s1_ready;

endmodule
